// File: rtl/ipf_pkg.sv
// Shared types and default geometry for the IPF feeder: state encoding,
// buffer/schedule defaults and the derived run length.
package ipf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_SEND_I   = 3'd2,
    ST_SEND_W   = 3'd3,
    ST_COMPUTE  = 3'd4,
    ST_WAIT_FIN = 3'd5
  } ipf_state_e;

  localparam int DEF_I_WIDTH     = 8;
  localparam int DEF_W_WIDTH     = 4;
  localparam int DEF_I_DEPTH     = 6;
  localparam int DEF_W_DEPTH     = 2;
  localparam int DEF_N_GROUPS    = 2;
  localparam int DEF_GROUP_I     = 3;
  localparam int DEF_W_PER_GROUP = 2;
  localparam int DEF_COMP_CYC    = 3;

  // Cycles from ARM entry up to (not including) WAIT_FIN.
  function automatic int run_cycles(input int n_groups, input int group_i,
                                    input int w_per_group, input int comp_cyc);
    return 1 + n_groups * (group_i + w_per_group * (1 + comp_cyc));
  endfunction

  localparam int DEF_RUN_CYCLES = run_cycles(DEF_N_GROUPS, DEF_GROUP_I,
                                             DEF_W_PER_GROUP, DEF_COMP_CYC);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ipf_feed_buf.sv
// Small register file: one synchronous write port, one asynchronous read port.
// Writes to addresses at or beyond DEPTH are discarded; contents are never reset.
module ipf_feed_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 6,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ipf_feeder.sv
// Transmit side of the IPF input protocol: replays the pixel and weight buffers
// into IPF in a fixed group schedule, then holds endinput until IPF reports finish.
module ipf_feeder
  import ipf_pkg::*;
#(
  parameter int I_WIDTH     = DEF_I_WIDTH,
  parameter int W_WIDTH     = DEF_W_WIDTH,
  parameter int I_DEPTH     = DEF_I_DEPTH,
  parameter int W_DEPTH     = DEF_W_DEPTH,
  parameter int N_GROUPS    = DEF_N_GROUPS,
  parameter int GROUP_I     = DEF_GROUP_I,
  parameter int W_PER_GROUP = DEF_W_PER_GROUP,
  parameter int COMP_CYC    = DEF_COMP_CYC,
  parameter int I_AW        = $clog2(I_DEPTH),
  parameter int W_AW        = $clog2(W_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_wr_en,
  input  logic [I_AW-1:0]    i_wr_addr,
  input  logic [I_WIDTH-1:0] i_wr_data,
  input  logic               w_wr_en,
  input  logic [W_AW-1:0]    w_wr_addr,
  input  logic [W_WIDTH-1:0] w_wr_data,
  input  logic               start,
  input  logic               finish,
  output logic               ready,
  output logic [I_WIDTH-1:0] i_data,
  output logic               i_valid,
  output logic [W_WIDTH-1:0] w_data,
  output logic               w_valid,
  output logic               endinput,
  output logic               busy,
  output logic               done,
  output ipf_state_e         dbg_state
);

  // Handshake: IPF has no back-pressure. A data beat is transferred in every
  // cycle its valid is high; ready marks the whole run window, endinput marks
  // that no further beats follow, and finish from IPF ends (or cuts short) the run.

  localparam int CNT_W  = $clog2(max2(GROUP_I, COMP_CYC) + 1);
  localparam int GRP_W  = $clog2(N_GROUPS + 1);
  localparam int PAIR_W = $clog2(W_PER_GROUP + 1);

  localparam logic [CNT_W-1:0]  LAST_I = CNT_W'(GROUP_I - 1);
  localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(COMP_CYC - 1);
  localparam logic [GRP_W-1:0]  LAST_G = GRP_W'(N_GROUPS - 1);
  localparam logic [PAIR_W-1:0] LAST_P = PAIR_W'(W_PER_GROUP - 1);
  localparam logic [W_AW-1:0]   LAST_W = W_AW'(W_DEPTH - 1);

  ipf_state_e         state;
  logic [I_AW-1:0]    i_ptr;
  logic [W_AW-1:0]    w_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [GRP_W-1:0]   group;
  logic [PAIR_W-1:0]  pair;

  logic [I_WIDTH-1:0] i_rd_data;
  logic [W_WIDTH-1:0] w_rd_data;
  logic               wr_allowed;
  logic [W_AW-1:0]    w_ptr_nxt;
  logic [I_AW-1:0]    i_ptr_nxt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               final_pair;

  assign wr_allowed = (state == ST_IDLE);
  assign w_ptr_nxt  = (w_ptr == LAST_W) ? '0 : w_ptr + 1'b1;
  assign i_ptr_nxt  = i_ptr + 1'b1;
  assign cnt_inc    = cnt + 1'b1;
  assign final_pair = (group == LAST_G) && (pair == LAST_P);
  assign dbg_state  = state;

  ipf_feed_buf #(
    .WIDTH (I_WIDTH),
    .DEPTH (I_DEPTH),
    .AW    (I_AW)
  ) u_ibuf (
    .clk     (clk),
    .wr_en   (i_wr_en && wr_allowed),
    .wr_addr (i_wr_addr),
    .wr_data (i_wr_data),
    .rd_addr (i_ptr),
    .rd_data (i_rd_data)
  );

  ipf_feed_buf #(
    .WIDTH (W_WIDTH),
    .DEPTH (W_DEPTH),
    .AW    (W_AW)
  ) u_wbuf (
    .clk     (clk),
    .wr_en   (w_wr_en && wr_allowed),
    .wr_addr (w_wr_addr),
    .wr_data (w_wr_data),
    .rd_addr (w_ptr),
    .rd_data (w_rd_data)
  );

  // Outputs are loaded on the edge that enters a state, so they describe the
  // state currently held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      i_ptr    <= '0;
      w_ptr    <= '0;
      cnt      <= '0;
      group    <= '0;
      pair     <= '0;
      ready    <= 1'b0;
      i_data   <= '0;
      i_valid  <= 1'b0;
      w_data   <= '0;
      w_valid  <= 1'b0;
      endinput <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state != ST_IDLE) && finish) begin
        state    <= ST_IDLE;
        ready    <= 1'b0;
        i_data   <= '0;
        i_valid  <= 1'b0;
        w_data   <= '0;
        w_valid  <= 1'b0;
        endinput <= 1'b0;
        busy     <= 1'b0;
        done     <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state <= ST_ARM;
              ready <= 1'b1;
              busy  <= 1'b1;
              i_ptr <= '0;
              w_ptr <= '0;
              cnt   <= '0;
              group <= '0;
              pair  <= '0;
            end
          end
          ST_ARM: begin
            state   <= ST_SEND_I;
            i_valid <= 1'b1;
            i_data  <= i_rd_data;
            i_ptr   <= i_ptr_nxt;
            cnt     <= '0;
          end
          ST_SEND_I: begin
            if (cnt == LAST_I) begin
              state   <= ST_SEND_W;
              i_valid <= 1'b0;
              i_data  <= '0;
              w_valid <= 1'b1;
              w_data  <= w_rd_data;
              w_ptr   <= w_ptr_nxt;
            end else begin
              cnt    <= cnt_inc;
              i_data <= i_rd_data;
              i_ptr  <= i_ptr_nxt;
            end
          end
          ST_SEND_W: begin
            state   <= ST_COMPUTE;
            w_valid <= 1'b0;
            w_data  <= '0;
            cnt     <= '0;
            if (final_pair && (LAST_C == '0)) begin
              endinput <= 1'b1;
            end
          end
          ST_COMPUTE: begin
            if (cnt == LAST_C) begin
              cnt <= '0;
              if (pair != LAST_P) begin
                pair    <= pair + 1'b1;
                state   <= ST_SEND_W;
                w_valid <= 1'b1;
                w_data  <= w_rd_data;
                w_ptr   <= w_ptr_nxt;
              end else if (group != LAST_G) begin
                group   <= group + 1'b1;
                pair    <= '0;
                state   <= ST_SEND_I;
                i_valid <= 1'b1;
                i_data  <= i_rd_data;
                i_ptr   <= i_ptr_nxt;
              end else begin
                state <= ST_WAIT_FIN;
              end
            end else begin
              cnt <= cnt_inc;
              // endinput appears on the final compute cycle of the last pair.
              if (final_pair && (cnt_inc == LAST_C)) begin
                endinput <= 1'b1;
              end
            end
          end
          ST_WAIT_FIN: begin
            state <= ST_WAIT_FIN;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ipf_feeder.sv
// Directed bench for ipf_feeder: full run schedule, ignored start/writes while
// busy, mid-run reset, early finish, and start/finish collision in IDLE.
module tb_ipf_feeder;
  import ipf_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_wr_en;
  logic [2:0] i_wr_addr;
  logic [7:0] i_wr_data;
  logic       w_wr_en;
  logic [0:0] w_wr_addr;
  logic [3:0] w_wr_data;
  logic       start;
  logic       finish;
  logic       ready;
  logic [7:0] i_data;
  logic       i_valid;
  logic [3:0] w_data;
  logic       w_valid;
  logic       endinput;
  logic       busy;
  logic       done;
  ipf_state_e dbg_state;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  ipf_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .w_wr_en   (w_wr_en),
    .w_wr_addr (w_wr_addr),
    .w_wr_data (w_wr_data),
    .start     (start),
    .finish    (finish),
    .ready     (ready),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .w_data    (w_data),
    .w_valid   (w_valid),
    .endinput  (endinput),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / time base
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic write_i(input logic [2:0] addr, input logic [7:0] data);
    i_wr_en = 1'b1; i_wr_addr = addr; i_wr_data = data;
    step();
    i_wr_en = 1'b0;
  endtask

  task automatic write_w(input logic [0:0] addr, input logic [3:0] data);
    w_wr_en = 1'b1; w_wr_addr = addr; w_wr_data = data;
    step();
    w_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ready"},    32'(ready),    32'd0);
    chk({tag, "_endinput"}, 32'(endinput), 32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_i_valid"},  32'(i_valid),  32'd0);
    chk({tag, "_w_valid"},  32'(w_valid),  32'd0);
    chk({tag, "_i_data"},   32'(i_data),   32'd0);
    chk({tag, "_w_data"},   32'(w_data),   32'd0);
  endtask

  // Hand-written schedule: cycle 1 = ARM, 23 = last compute, 24+ = WAIT_FIN.
  task automatic check_cycle(input int c);
    logic       e_iv, e_wv, e_ei;
    logic [7:0] e_id;
    logic [3:0] e_wd;
    string      t;
    e_iv = 1'b0; e_wv = 1'b0; e_id = 8'h00; e_wd = 4'h0;
    e_ei = (c >= 23);
    case (c)
      2:  begin e_iv = 1'b1; e_id = 8'd1; end
      3:  begin e_iv = 1'b1; e_id = 8'd2; end
      4:  begin e_iv = 1'b1; e_id = 8'd3; end
      13: begin e_iv = 1'b1; e_id = 8'd4; end
      14: begin e_iv = 1'b1; e_id = 8'd5; end
      15: begin e_iv = 1'b1; e_id = 8'd6; end
      5, 16: begin e_wv = 1'b1; e_wd = 4'hA; end
      9, 20: begin e_wv = 1'b1; e_wd = 4'h5; end
      default: ;
    endcase
    t = $sformatf("c%0d", c);
    chk({t, "_ready"},    32'(ready),    32'd1);
    chk({t, "_busy"},     32'(busy),     32'd1);
    chk({t, "_done"},     32'(done),     32'd0);
    chk({t, "_i_valid"},  32'(i_valid),  32'(e_iv));
    chk({t, "_i_data"},   32'(i_data),   32'(e_id));
    chk({t, "_w_valid"},  32'(w_valid),  32'(e_wv));
    chk({t, "_w_data"},   32'(w_data),   32'(e_wd));
    chk({t, "_endinput"}, 32'(endinput), 32'(e_ei));
    if (i_valid === 1'b1 && exp_q.size() > 0) begin
      chk({t, "_sb_pixel"}, 32'(i_data), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; finish = 1'b0;
    i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
    step();
    step();
    chk_idle_zero("reset");
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) write_i(3'(i), 8'(i + 1));
    write_w(1'b0, 4'hA);
    write_w(1'b1, 4'h5);
    chk("load_busy", 32'(busy), 32'd0);

    // Run 1: full schedule, with start and a buffer write injected mid-run.
    for (int i = 1; i <= 6; i++) exp_q.push_back(8'(i));
    pulse_start();
    check_cycle(1);
    for (int c = 1; c <= 26; c++) begin
      if (c == 6) begin
        start = 1'b1;
        i_wr_en = 1'b1; i_wr_addr = 3'd0; i_wr_data = 8'hFF;
      end
      step();
      start = 1'b0;
      i_wr_en = 1'b0;
      check_cycle(c + 1);
    end
    chk("run1_sb_empty", 32'(exp_q.size()), 32'd0);
    finish = 1'b1;
    step();
    finish = 1'b0;
    chk("fin_done",     32'(done),     32'd1);
    chk("fin_ready",    32'(ready),    32'd0);
    chk("fin_endinput", 32'(endinput), 32'd0);
    chk("fin_busy",     32'(busy),     32'd0);
    step();
    chk("fin_done_pulse", 32'(done), 32'd0);

    // Run 2: replay shows ibuf[0] kept; reset during the second pixel group.
    pulse_start();
    check_cycle(1);
    for (int c = 1; c <= 13; c++) begin
      step();
      check_cycle(c + 1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle_zero("midrst");
    chk("midrst_done", 32'(done), 32'd0);

    // Run 3: fresh start replays from pixel 1 / weight A; finish forced at cycle 8.
    pulse_start();
    check_cycle(1);
    for (int c = 1; c <= 7; c++) begin
      step();
      check_cycle(c + 1);
    end
    finish = 1'b1;
    step();
    finish = 1'b0;
    chk("abort_done",     32'(done),     32'd1);
    chk("abort_ready",    32'(ready),    32'd0);
    chk("abort_busy",     32'(busy),     32'd0);
    chk("abort_endinput", 32'(endinput), 32'd0);
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("abort_quiet%0d_endinput", k), 32'(endinput), 32'd0);
      chk($sformatf("abort_quiet%0d_busy", k),     32'(busy),     32'd0);
    end

    // start and finish together in IDLE: start wins.
    start = 1'b1; finish = 1'b1;
    step();
    start = 1'b0; finish = 1'b0;
    chk("collide_ready", 32'(ready), 32'd1);
    chk("collide_busy",  32'(busy),  32'd1);
    chk("collide_done",  32'(done),  32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("end_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
